fib_arbiter: RTL

//  Shares one iterative fib engine (vld_in/rdy_in in, vld_out/rdy_out out) among NUM_REQ requesters.

---
 rtl/fib_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fib_arbiter.sv
// Round-robin front end that shares one iterative fib engine among NUM_REQ requesters.
// Optional single-entry result cache enabled by defining FIB_ARB_CACHE_EN.
module fib_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int FIB_OUT_WIDTH = 180
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_vld,
    input  logic [NUM_REQ*8-1:0]     req_idx,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic [NUM_REQ-1:0]       rsp_vld,
    output logic [FIB_OUT_WIDTH-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]       rsp_rdy,
    output logic                     eng_vld_in,
    output logic [7:0]               eng_fib_in,
    input  logic                     eng_rdy_in,
    input  logic                     eng_vld_out,
    input  logic [FIB_OUT_WIDTH-1:0] eng_fib_out,
    output logic                     eng_rdy_out
);

    // state | meaning
    // IDLE  | scanning requesters round-robin, accept one winner
    // ISSUE | presenting idx_q to the engine until it takes it
    // WAIT  | engine computing; consume its result on vld_out
    // RESP  | result_q offered to the owner until it accepts
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]               state;
    logic [PW-1:0]            rr_ptr;
    logic [PW-1:0]            owner;
    logic [7:0]               idx_q;
    logic [FIB_OUT_WIDTH-1:0] result_q;

    logic                     found;
    logic [PW-1:0]            winner;
    logic [7:0]               win_idx;
    logic                     cache_hit;
    int                       cand;

    // Scan starts one past the last served channel so every requester rotates fairly.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        win_idx = '0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_vld[cand]) begin
                found   = 1'b1;
                winner  = PW'(cand);
                win_idx = req_idx[8*cand +: 8];
            end
        end
    end

`ifdef FIB_ARB_CACHE_EN
    logic                     cache_vld;
    logic [7:0]               cache_idx;
    logic [FIB_OUT_WIDTH-1:0] cache_val;

    assign cache_hit = cache_vld && (win_idx == cache_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld <= 1'b0;
            cache_idx <= '0;
            cache_val <= '0;
        end else if (state == S_WAIT && eng_vld_out) begin
            cache_vld <= 1'b1;
            cache_idx <= idx_q;
            cache_val <= eng_fib_out;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rr_ptr   <= PW'(NUM_REQ - 1);
            owner    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner <= winner;
                        idx_q <= win_idx;
`ifdef FIB_ARB_CACHE_EN
                        if (cache_hit) begin
                            result_q <= cache_val;
                            state    <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
`else
                        state <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    if (eng_rdy_in) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_vld_out) begin
                        result_q <= eng_fib_out;
                        state    <= S_RESP;
                    end
                end
                default: begin
                    if (rsp_rdy[owner]) begin
                        rr_ptr <= owner;
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        req_rdy = '0;
        rsp_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rdy[i] = (state == S_IDLE) && found && (winner == PW'(i));
            rsp_vld[i] = (state == S_RESP) && (owner == PW'(i));
        end
    end

    assign rsp_data    = result_q;
    assign eng_vld_in  = (state == S_ISSUE);
    assign eng_fib_in  = (state == S_ISSUE) ? idx_q : 8'd0;
    assign eng_rdy_out = (state == S_WAIT) && eng_vld_out;

endmodule
